// File: rtl/dp_rr_sched_if.sv
// dp_rr_sched_if: requester, pipeline and status bundle for dp_rr_sched.
// slave = scheduler side, master = requesters/pipeline/consumer side.
//   req_vld_i/req_dat_i/req_last_i/req_rdy_o : per-requester valid/ready beats
//   dp_vld_o/dp_dat_o/dp_id_o/dp_stall_o     : pipeline inject and stall
//   dp_out_vld_i/out_rdy_i                   : pipeline head and consumer ready
//   occ_o/idle_o                             : occupancy and drain status
interface dp_rr_sched_if #(
  parameter int R = 4,
  parameter int W = 32,
  parameter int D = 4
);
  localparam int IDW = $clog2(R);
  localparam int OCW = $clog2(D + 1);

  logic [R-1:0]        req_vld_i;
  logic [R-1:0][W-1:0] req_dat_i;
  logic [R-1:0]        req_last_i;
  logic [R-1:0]        req_rdy_o;
  logic                dp_vld_o;
  logic [W-1:0]        dp_dat_o;
  logic [IDW-1:0]      dp_id_o;
  logic                dp_stall_o;
  logic                dp_out_vld_i;
  logic                out_rdy_i;
  logic [OCW-1:0]      occ_o;
  logic                idle_o;

  modport slave (
    input  req_vld_i,
    input  req_dat_i,
    input  req_last_i,
    input  dp_out_vld_i,
    input  out_rdy_i,
    output req_rdy_o,
    output dp_vld_o,
    output dp_dat_o,
    output dp_id_o,
    output dp_stall_o,
    output occ_o,
    output idle_o
  );

  modport master (
    output req_vld_i,
    output req_dat_i,
    output req_last_i,
    output dp_out_vld_i,
    output out_rdy_i,
    input  req_rdy_o,
    input  dp_vld_o,
    input  dp_dat_o,
    input  dp_id_o,
    input  dp_stall_o,
    input  occ_o,
    input  idle_o
  );
endinterface

// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin scheduler sharing one stallable pipeline.
// Ports: clk, arst (async, active-high), bus (dp_rr_sched_if.slave).
//   Grants are held for whole packets (until req_last_i).
//   Stall = pipeline head valid and consumer not ready.
//   occ_o counts beats resident in the pipeline; idle_o flags drain.
module dp_rr_sched #(
  parameter int R = 4,
  parameter int W = 32,
  parameter int D = 4
) (
  input logic          clk,
  input logic          arst,
  dp_rr_sched_if.slave bus
);
  localparam int IDW = $clog2(R);
  localparam int OCW = $clog2(D + 1);
  localparam logic [OCW-1:0] OCC_MAX = OCW'(D);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [IDW-1:0]  r_lock_id;
  logic [IDW-1:0]  w_lock_nxt;
  logic [OCW-1:0]  r_occ;
  logic [OCW-1:0]  w_occ_nxt;

  logic [IDW-1:0]  w_win;
  logic            w_win_vld;
  logic            w_stall;
  logic            w_accept;
  logic            w_last;
  logic            w_inc;
  logic            w_dec;

  // (a + k) mod R, for a < R and k < R
  function automatic logic [IDW-1:0] wrap_add(
    input logic [IDW-1:0] a,
    input int unsigned    k
  );
    logic [IDW:0] s;
    s = {1'b0, a} + (IDW+1)'(k);
    if (s >= (IDW+1)'(R)) s = s - (IDW+1)'(R);
    return s[IDW-1:0];
  endfunction

  assign w_stall = bus.dp_out_vld_i & ~bus.out_rdy_i;

  // LOCKED looks only at lock_id, so other valids never reach rdy.
  // IDLE scans downward so the candidate nearest rr_ptr wins.
  always_comb begin
    w_win     = r_rr_ptr;
    w_win_vld = 1'b0;
    if (r_state == S_LOCKED) begin
      w_win     = r_lock_id;
      w_win_vld = bus.req_vld_i[r_lock_id];
    end else begin
      for (int k = R - 1; k >= 0; k--) begin
        if (bus.req_vld_i[wrap_add(r_rr_ptr, k)]) begin
          w_win     = wrap_add(r_rr_ptr, k);
          w_win_vld = 1'b1;
        end
      end
    end
  end

  // Holding reset also blocks injection so outputs stay quiet.
  assign w_accept = w_win_vld & ~w_stall & ~arst;
  assign w_last   = bus.req_last_i[w_win];

  assign bus.req_rdy_o  = w_accept ?
    ({{(R-1){1'b0}}, 1'b1} << w_win) : '0;
  assign bus.dp_vld_o   = w_accept;
  assign bus.dp_dat_o   = w_accept ? bus.req_dat_i[w_win] : '0;
  assign bus.dp_id_o    = w_accept ? w_win : '0;
  assign bus.dp_stall_o = w_stall;
  assign bus.occ_o      = r_occ;
  assign bus.idle_o     = (r_occ == '0) && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_lock_nxt  = r_lock_id;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_last) begin
            w_ptr_nxt = wrap_add(w_win, 1);
          end else begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = w_win;
          end
        end
      end
      S_LOCKED: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = wrap_add(r_lock_id, 1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_inc = w_accept;
  assign w_dec = bus.dp_out_vld_i & bus.out_rdy_i;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_inc, w_dec})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_occ     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_ptr_nxt;
      r_lock_id <= w_lock_nxt;
      r_occ     <= w_occ_nxt;
    end
  end

  a_rdy_onehot: assert property (
    @(posedge clk) disable iff (arst)
    $onehot0(bus.req_rdy_o));

  a_vld_nostall: assert property (
    @(posedge clk) disable iff (arst)
    bus.dp_vld_o |-> !bus.dp_stall_o);

  a_occ_max: assert property (
    @(posedge clk) disable iff (arst)
    r_occ <= OCC_MAX);

  a_no_underflow: assert property (
    @(posedge clk) disable iff (arst)
    !(w_dec && (r_occ == '0)));
endmodule
